ifetch_align_unit: RTL and testbench
====================================

Name: ifetch_align_unit

Overview:
- Instruction fetch stage for the RV32IC core. Sits directly upstream of the instruction memory: drives its 6-bit word address and consumes its combinational 32-bit read data.
- Extracts 16-bit compressed and 32-bit instructions from halfword-aligned PCs, including 32-bit instructions that straddle a word boundary.
- Presents one instruction per transfer to decode through a registered valid/ready output stage.
- Supports PC redirect (branch/jump) with flush.

Parameters:
- RESET_PC, 32'h0000_0000, byte PC loaded on reset (bit 0 ignored)
- ADDR_W, 6, instruction-memory word-address width (64 words)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_addr  out  ADDR_W  word address to instruction memory (combinational from state)
- imem_data  in  32  instruction memory read data, combinational from imem_addr
- redirect_valid  in  1  load new PC and flush this cycle
- redirect_pc  in  32  redirect target byte address
- out_ready  in  1  decode accepts out_* this cycle
- out_valid  out  1  out_* holds a valid instruction
- out_instr  out  32  instruction; compressed is zero-extended in [15:0]
- out_pc  out  32  byte address of out_instr
- out_compressed  out  1  out_instr is a 16-bit instruction

Behaviour:
- Reset (async, rst_n=0):
  - pc <= {RESET_PC[31:1],0}; state <= RUN; halfword buffer <= 0.
  - out_valid, out_instr, out_pc and out_compressed all go to 0 immediately.
- Advance condition: adv = !out_valid || out_ready. When adv=0, pc, state, buffer and out_* hold, and imem_addr is stable.
- imem_addr:
  - RUN: pc[ADDR_W+1:2].
  - SPLIT: pc[ADDR_W+1:2]+1, modulo 2^ADDR_W (word 63 wraps to word 0).
- RUN with pc[1]=0, word w = imem_data:
  - w[1:0]!=2'b11: emit {16'h0,w[15:0]}, compressed=1, pc+=2.
  - Otherwise: emit w, compressed=0, pc+=4.
- RUN with pc[1]=1, halfword h = imem_data[31:16]:
  - h[1:0]!=2'b11: emit {16'h0,h}, compressed=1, pc+=2.
  - Otherwise: buffer h, state <= SPLIT, pc unchanged, out_valid <= 0 (one bubble).
- SPLIT: emit {imem_data[15:0],buffer}, compressed=0, out_pc=pc, pc+=4, state <= RUN.
- Emit means: on the clock edge with adv=1, out_valid<=1 and out_instr/out_pc/out_compressed are loaded. Latency: instruction at pc appears one clock after pc is presented. A split instruction costs one extra cycle.
- Throughput: one instruction per cycle when out_ready=1 and no split.
- pc arithmetic: full 32-bit, wraps modulo 2^32. Only pc[ADDR_W+1:1] affects fetch; out_pc reports the full value.
- Redirect (redirect_valid=1 at a clock edge):
  - Highest priority, independent of out_ready.
  - pc <= {redirect_pc[31:1],0}, state <= RUN, buffer cleared, out_valid <= 0.
  - Any pending or split instruction is discarded.
  - Fetch at the new PC produces output on the following edge (if adv).
- Simultaneous redirect and out_ready=0: redirect wins, and the held output is dropped.
- Buffered halfword is never emitted alone. A split that is stalled holds the buffer and SPLIT state until adv.
- No illegal-instruction checking. 16'h0000 is passed through as compressed.
- States: RUN, SPLIT. No other states are reachable.

Test Plan:
- Reset release, RESET_PC=0, word0=0x00002083, out_ready=1 → first edge: out_valid=1, out_instr=0x00002083, out_pc=0, out_compressed=0; next imem_addr=1.
- Word1=0x45050085 → consecutive outputs 0x00000085 @pc 4 (compressed=1), then 0x00004505 @pc 6 (compressed=1), then imem_addr=2.
- Word2=0x20830001, word3=0x12340000 → 0x00000001 @pc 8 (compressed), one cycle out_valid=0 with imem_addr=3, then 0x00002083 @pc 10 (compressed=0), then 0x00001234 @pc 14 (compressed).
- Backpressure: out_valid=1, hold out_ready=0 for 3 cycles → out_instr/out_pc/imem_addr unchanged; out_ready=1 → next instruction on the following edge, none skipped or duplicated.
- Redirect during SPLIT with redirect_pc=0x21 and out_ready=0 → next edge out_valid=0, imem_addr=8; following edge out_pc=0x20 with the word8 instruction.
- Wrap: RESET_PC=0xFE, word63[31:16]=0x2083, word0[15:0]=0x0000 → SPLIT fetches imem_addr=0, emits 0x00002083 @pc 0xFE, next out_pc=0x102. Assert rst_n=0 mid-SPLIT → out_valid=0 immediately, pc=RESET_PC.

Source files
------------

// File: rtl/ifetch_align_unit.sv
// RV32IC instruction fetch and align stage: extracts 16/32-bit instructions from a
// word-wide instruction memory, including 32-bit instructions straddling a word boundary.
module ifetch_align_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    output logic              out_compressed
);

    typedef enum logic {RUN, SPLIT} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [15:0] half_buf;

    logic              adv;
    logic [ADDR_W-1:0] word_addr;

    logic        emit;
    logic [31:0] emit_instr;
    logic        emit_comp;
    logic [31:0] pc_step;
    logic        go_split;

    assign adv       = !out_valid || out_ready;
    assign word_addr = pc[ADDR_W+1:2];
    // SPLIT reads the word after pc for the upper half; the add wraps within ADDR_W bits
    assign imem_addr = (state == SPLIT) ? word_addr + 1'b1 : word_addr;

    always_comb begin
        emit       = 1'b0;
        emit_instr = '0;
        emit_comp  = 1'b0;
        pc_step    = 32'd0;
        go_split   = 1'b0;
        case (state)
            RUN: begin
                if (!pc[1]) begin
                    emit = 1'b1;
                    if (imem_data[1:0] != 2'b11) begin
                        emit_instr = {16'h0000, imem_data[15:0]};
                        emit_comp  = 1'b1;
                        pc_step    = 32'd2;
                    end else begin
                        emit_instr = imem_data;
                        pc_step    = 32'd4;
                    end
                end else if (imem_data[17:16] != 2'b11) begin
                    emit       = 1'b1;
                    emit_instr = {16'h0000, imem_data[31:16]};
                    emit_comp  = 1'b1;
                    pc_step    = 32'd2;
                end else begin
                    go_split = 1'b1;
                end
            end
            SPLIT: begin
                emit       = 1'b1;
                emit_instr = {imem_data[15:0], half_buf};
                pc_step    = 32'd4;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= RESET_PC & ~32'h1;
            state          <= RUN;
            half_buf       <= '0;
            out_valid      <= 1'b0;
            out_instr      <= '0;
            out_pc         <= '0;
            out_compressed <= 1'b0;
        end else if (redirect_valid) begin
            pc        <= redirect_pc & ~32'h1;
            state     <= RUN;
            half_buf  <= '0;
            out_valid <= 1'b0;
        end else if (adv) begin
            pc <= pc + pc_step;
            if (go_split) begin
                half_buf  <= imem_data[31:16];
                state     <= SPLIT;
                out_valid <= 1'b0;
            end else begin
                state <= RUN;
                if (state == SPLIT) begin
                    half_buf <= '0;
                end
                out_valid      <= emit;
                out_instr      <= emit_instr;
                out_pc         <= pc;
                out_compressed <= emit_comp;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_align_unit.sv
// Directed bench for ifetch_align_unit: one instance at RESET_PC=0, one at 0xFE for wrap.
module tb_ifetch_align_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // main instance
    logic        rst_a, redirect_valid, out_ready;
    logic [31:0] redirect_pc;
    logic [5:0]  imem_addr_a;
    logic [31:0] imem_data_a;
    logic        out_valid_a, out_comp_a;
    logic [31:0] out_instr_a, out_pc_a;
    logic [31:0] mem_a [64];
    assign imem_data_a = mem_a[imem_addr_a];

    // wrap instance
    logic        rst_w, redirect_w, ready_w;
    logic [5:0]  imem_addr_w;
    logic [31:0] imem_data_w;
    logic        out_valid_w, out_comp_w;
    logic [31:0] out_instr_w, out_pc_w;
    logic [31:0] mem_w [64];
    assign imem_data_w = mem_w[imem_addr_w];

    ifetch_align_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(6)) dut (
        .clk(clk), .rst_n(rst_a),
        .imem_addr(imem_addr_a), .imem_data(imem_data_a),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_ready(out_ready), .out_valid(out_valid_a),
        .out_instr(out_instr_a), .out_pc(out_pc_a), .out_compressed(out_comp_a)
    );

    ifetch_align_unit #(.RESET_PC(32'h0000_00FE), .ADDR_W(6)) dut_wrap (
        .clk(clk), .rst_n(rst_w),
        .imem_addr(imem_addr_w), .imem_data(imem_data_w),
        .redirect_valid(redirect_w), .redirect_pc(32'h0),
        .out_ready(ready_w), .out_valid(out_valid_w),
        .out_instr(out_instr_w), .out_pc(out_pc_w), .out_compressed(out_comp_w)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic chk_a(input string tag, input logic v, input logic [31:0] i,
                         input logic [31:0] p, input logic c);
        chk({tag, ".valid"}, 32'(out_valid_a), 32'(v));
        chk({tag, ".instr"}, out_instr_a, i);
        chk({tag, ".pc"}, out_pc_a, p);
        chk({tag, ".comp"}, 32'(out_comp_a), 32'(c));
    endtask

    task automatic chk_w(input string tag, input logic v, input logic [31:0] i,
                         input logic [31:0] p, input logic c);
        chk({tag, ".valid"}, 32'(out_valid_w), 32'(v));
        chk({tag, ".instr"}, out_instr_w, i);
        chk({tag, ".pc"}, out_pc_w, p);
        chk({tag, ".comp"}, 32'(out_comp_w), 32'(c));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = 32'h0;
            mem_w[i] = 32'h0;
        end
        mem_a[0]  = 32'h0000_2083;
        mem_a[1]  = 32'h4505_0085;
        mem_a[2]  = 32'h2083_0001;
        mem_a[3]  = 32'h1234_0000;
        mem_a[4]  = 32'h00A0_0513;
        mem_a[5]  = 32'h0593_4501;
        mem_a[8]  = 32'h00C5_8593;
        mem_a[12] = 32'h0000_0000;
        mem_w[63] = 32'h2083_0001;
        mem_w[0]  = 32'h4501_0000;
        mem_w[1]  = 32'h0083_0001;

        rst_a = 1'b0; rst_w = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
        redirect_w = 1'b0; ready_w = 1'b1;

        #2;
        chk_a("reset", 1'b0, 32'h0, 32'h0, 1'b0);
        chk("reset.addr", 32'(imem_addr_a), 32'd0);

        @(negedge clk);
        rst_a = 1'b1;
        tick(); chk_a("w0", 1'b1, 32'h0000_2083, 32'h0, 1'b0);
        chk("w0.addr", 32'(imem_addr_a), 32'd1);
        tick(); chk_a("c4", 1'b1, 32'h0000_0085, 32'h4, 1'b1);
        tick(); chk_a("c6", 1'b1, 32'h0000_4505, 32'h6, 1'b1);
        chk("c6.addr", 32'(imem_addr_a), 32'd2);
        tick(); chk_a("c8", 1'b1, 32'h0000_0001, 32'h8, 1'b1);
        tick(); chk("bubble.valid", 32'(out_valid_a), 32'd0);
        chk("bubble.addr", 32'(imem_addr_a), 32'd3);
        tick(); chk_a("split10", 1'b1, 32'h0000_2083, 32'hA, 1'b0);
        tick(); chk_a("c14", 1'b1, 32'h0000_1234, 32'hE, 1'b1);

        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(); chk_a("hold", 1'b1, 32'h0000_1234, 32'hE, 1'b1);
            chk("hold.addr", 32'(imem_addr_a), 32'd4);
        end
        out_ready = 1'b1;
        tick(); chk_a("resume", 1'b1, 32'h00A0_0513, 32'h10, 1'b0);
        tick(); chk_a("c20", 1'b1, 32'h0000_4501, 32'h14, 1'b1);
        tick(); chk("split22.valid", 32'(out_valid_a), 32'd0);
        chk("split22.addr", 32'(imem_addr_a), 32'd6);

        out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h21;
        tick(); redirect_valid = 1'b0;
        chk("redir.valid", 32'(out_valid_a), 32'd0);
        chk("redir.addr", 32'(imem_addr_a), 32'd8);
        tick(); chk_a("redir.w8", 1'b1, 32'h00C5_8593, 32'h20, 1'b0);

        redirect_valid = 1'b1; redirect_pc = 32'h30;
        tick(); redirect_valid = 1'b0;
        chk("drop.valid", 32'(out_valid_a), 32'd0);
        chk("drop.addr", 32'(imem_addr_a), 32'd12);
        out_ready = 1'b1;
        tick(); chk_a("zero16", 1'b1, 32'h0, 32'h30, 1'b1);

        chk("wreset.addr", 32'(imem_addr_w), 32'd63);
        chk("wreset.valid", 32'(out_valid_w), 32'd0);
        @(negedge clk);
        rst_w = 1'b1;
        tick(); chk("wsplit.valid", 32'(out_valid_w), 32'd0);
        chk("wsplit.addr", 32'(imem_addr_w), 32'd0);
        tick(); chk_w("wrapFE", 1'b1, 32'h0000_2083, 32'hFE, 1'b0);
        chk("wrapFE.addr", 32'(imem_addr_w), 32'd0);
        tick(); chk_w("w102", 1'b1, 32'h0000_4501, 32'h102, 1'b1);
        tick(); chk_w("w104", 1'b1, 32'h0000_0001, 32'h104, 1'b1);
        tick(); chk("w106.valid", 32'(out_valid_w), 32'd0);
        chk("w106.addr", 32'(imem_addr_w), 32'd2);
        #1 rst_w = 1'b0;
        #1;
        chk_w("async_rst", 1'b0, 32'h0, 32'h0, 1'b0);
        chk("async_rst.addr", 32'(imem_addr_w), 32'd63);
        @(negedge clk);
        rst_w = 1'b1;
        tick(); chk("rerun.valid", 32'(out_valid_w), 32'd0);
        chk("rerun.addr", 32'(imem_addr_w), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
